// File: rtl/blink_scheduler_if.sv
// Board-side bundle for blink_scheduler: run control, the configuration write
// port and the LED outputs. The master (board / bench) drives run and cfg_*,
// the slave (scheduler) drives led and running.
//
// Handshake: cfg_we is a one-cycle strobe with no ready or ack. The scheduler
// accepts a write on every edge where cfg_we is high, in any state, so the
// master may issue at most one write per cycle and never has to wait.
interface blink_scheduler_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 4
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              run;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_interval;
    logic              cfg_random;
    logic [NUM_CH-1:0] led;
    logic              running;

    modport master (
        output run,
        output cfg_we,
        output cfg_ch,
        output cfg_interval,
        output cfg_random,
        input  led,
        input  running
    );

    modport slave (
        input  run,
        input  cfg_we,
        input  cfg_ch,
        input  cfg_interval,
        input  cfg_random,
        output led,
        output running
    );
endinterface

// File: rtl/blink_scheduler.sv
// blink_scheduler: sequences NUM_CH LED channels. Each channel counts down
// its reload value and emits a one-cycle registered led pulse when the count
// expires. The reload value is either the channel's programmed interval or a
// pseudo-random draw from a free-running 16-bit Fibonacci LFSR.
//
// Channel timing: the counters are loaded on the IDLE->ARM edge, so during the
// single ARM cycle every cnt already holds its reload value and led is 0. From
// the ARM->RUN edge onwards each edge either decrements (cnt>1), pulses and
// reloads (cnt==1) or reloads silently (cnt==0, a channel just enabled). With
// a fixed interval N the first pulse is therefore registered N edges after
// the ARM edge and the period is exactly N; N=1 keeps led high.
//
// Configuration goes to a shadow register per channel. The running count is
// never touched by a write; the new value is picked up at the next reload or
// at the next ARM. A reload on the same edge as a write uses the old value,
// which falls out naturally because reload is decoded from the registered
// shadow state.
//
// LFSR_SEED must be nonzero (an all-zero Fibonacci LFSR locks up), and
// NUM_CH*CNT_W must not exceed 16 so that every channel has its own slice.
module blink_scheduler #(
    parameter int                      NUM_CH        = 3,
    parameter int                      CNT_W         = 4,
    parameter logic [15:0]             LFSR_SEED     = 16'hACE1,
    parameter int                      RAND_MIN      = 2,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_INTERVALS = {4'd0, 4'd5, 4'd10},
    parameter logic [NUM_CH-1:0]       DEF_RANDOM    = 3'b100
) (
    input  logic                clk,
    input  logic                rstbtn,
    blink_scheduler_if.slave    bus,
    output logic [1:0]          state_dbg
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RMIN     = CNT_W'(RAND_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  sh_int  [NUM_CH];
    logic [NUM_CH-1:0] sh_rnd;
    logic [CNT_W-1:0]  draw    [NUM_CH];
    logic [CNT_W-1:0]  reload  [NUM_CH];
    logic [NUM_CH-1:0] led_q;
    logic              running_q;

    assign bus.led     = led_q;
    assign bus.running = running_q;
    assign state_dbg   = state;

    // Feedback for x^16+x^14+x^13+x^11+1, shifting right into bit 15.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Per-channel reload value decoded from the current shadow config and LFSR.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            draw[i] = lfsr[i*CNT_W +: CNT_W];
            if (draw[i] < RMIN) begin
                draw[i] = RMIN;
            end
            if (sh_int[i] == CNT_ZERO) begin
                reload[i] = CNT_ZERO;
            end else if (sh_rnd[i]) begin
                reload[i] = draw[i];
            end else begin
                reload[i] = sh_int[i];
            end
        end
    end

    // Scheduler FSM with LFSR, shadow config, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rstbtn) begin
            state     <= IDLE;
            led_q     <= '0;
            running_q <= 1'b0;
            lfsr      <= LFSR_SEED;
            sh_rnd    <= DEF_RANDOM;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= CNT_ZERO;
                sh_int[i] <= DEF_INTERVALS[i*CNT_W +: CNT_W];
            end
        end else begin
            // The LFSR free-runs in every state.
            lfsr <= {lfsr_fb, lfsr[15:1]};

            // Shadow writes; channel indices past NUM_CH match nothing.
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
                    sh_int[i] <= bus.cfg_interval;
                    sh_rnd[i] <= bus.cfg_random;
                end
            end

            if (!bus.run) begin
                // Stop from any state, including ARM: clear counters and pulses.
                state     <= IDLE;
                led_q     <= '0;
                running_q <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i] <= CNT_ZERO;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state     <= ARM;
                        led_q     <= '0;
                        running_q <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt[i] <= reload[i];
                        end
                    end
                    ARM, RUN: begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cnt[i] == CNT_ONE) begin
                                led_q[i] <= 1'b1;
                                cnt[i]   <= reload[i];
                            end else if (cnt[i] > CNT_ONE) begin
                                led_q[i] <= 1'b0;
                                cnt[i]   <= cnt[i] - CNT_ONE;
                            end else begin
                                led_q[i] <= 1'b0;
                                cnt[i]   <= reload[i];
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        led_q     <= '0;
                        running_q <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt[i] <= CNT_ZERO;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler. Every edge, a behavioural model of the
// scheduler predicts {running, led}; the prediction is queued before the edge
// and popped and compared after it. On top of that, each scenario checks the
// recorded led history against pulse positions worked out by hand.
module tb_blink_scheduler;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;

    logic       clk = 1'b0;
    logic       rstbtn;
    logic [1:0] state_dbg;

    blink_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    blink_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstbtn    (rstbtn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         edge_n   = 0;
    logic [3:0] exp_q [$];
    logic [3:0] gap_q [$];
    logic [2:0] hist     [128];
    logic       hist_run [128];
    logic       track_gaps = 1'b0;

    // Reference model state
    int         m_state;
    logic [3:0] m_cnt [3];
    logic [3:0] m_int [3];
    logic [2:0] m_rnd;
    logic [15:0] m_lfsr;
    logic [2:0] m_led;
    logic       m_running;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic periodic(input int k, input int first, input int period);
        return (k >= first) && (((k - first) % period) == 0);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] rl [3];
        logic [3:0] r;
        if (rstbtn) begin
            m_state   = 0;
            m_led     = 3'b000;
            m_running = 1'b0;
            m_int[0]  = 4'd10;
            m_int[1]  = 4'd5;
            m_int[2]  = 4'd0;
            m_rnd     = 3'b100;
            m_lfsr    = 16'hACE1;
            for (int c = 0; c < 3; c++) m_cnt[c] = 4'd0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                r = m_lfsr[c*4 +: 4];
                if (r < 4'd2) r = 4'd2;
                if (m_int[c] == 4'd0) rl[c] = 4'd0;
                else rl[c] = m_rnd[c] ? r : m_int[c];
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            for (int c = 0; c < 3; c++) begin
                if (bus.cfg_we && (int'(bus.cfg_ch) == c)) begin
                    m_int[c] = bus.cfg_interval;
                    m_rnd[c] = bus.cfg_random;
                end
            end
            if (!bus.run) begin
                m_state   = 0;
                m_led     = 3'b000;
                m_running = 1'b0;
                for (int c = 0; c < 3; c++) m_cnt[c] = 4'd0;
            end else if (m_state == 0) begin
                m_state   = 1;
                m_led     = 3'b000;
                m_running = 1'b0;
                for (int c = 0; c < 3; c++) m_cnt[c] = rl[c];
                if (track_gaps) gap_q.push_back(rl[2]);
            end else begin
                m_state   = 2;
                m_running = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    if (m_cnt[c] == 4'd1) begin
                        m_led[c] = 1'b1;
                        m_cnt[c] = rl[c];
                        if (track_gaps && c == 2) gap_q.push_back(rl[2]);
                    end else if (m_cnt[c] > 4'd1) begin
                        m_led[c] = 1'b0;
                        m_cnt[c] = m_cnt[c] - 4'd1;
                    end else begin
                        m_led[c] = 1'b0;
                        m_cnt[c] = rl[c];
                    end
                end
            end
        end
    endtask

    // One clock: predict, wait for the edge, compare 1 time unit later.
    task automatic tick();
        logic [3:0] obs;
        logic [3:0] exp;
        model_edge();
        exp_q.push_back({m_running, m_led});
        @(posedge clk);
        #1;
        edge_n++;
        obs = {bus.running, bus.led};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL scoreboard edge=%0d observed=%b expected=%b", edge_n, obs, exp);
        end
        if (edge_n < 128) begin
            hist[edge_n]     = bus.led;
            hist_run[edge_n] = bus.running;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [3:0] iv, input logic rnd);
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = ch;
        bus.cfg_interval = iv;
        bus.cfg_random   = rnd;
        tick();
        bus.cfg_we       = 1'b0;
    endtask

    initial begin
        int last;
        int npulse;
        logic [3:0] g_exp;

        rstbtn           = 1'b1;
        bus.run          = 1'b0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = 2'd0;
        bus.cfg_interval = 4'd0;
        bus.cfg_random   = 1'b0;
        repeat (3) tick();
        chk("reset_led", bus.led, 3'b000);
        chk("reset_running", bus.running, 1'b0);

        // Test 1: defaults, run from the first edge after reset
        rstbtn  = 1'b0;
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (32) tick();
        chk("t1_running_e1", hist_run[1], 1'b0);
        chk("t1_running_e2", hist_run[2], 1'b1);
        for (int k = 1; k <= 32; k++) begin
            chk($sformatf("t1_ch0_e%0d", k), hist[k][0], periodic(k, 11, 10));
            chk($sformatf("t1_ch1_e%0d", k), hist[k][1], periodic(k, 6, 5));
            chk($sformatf("t1_ch2_e%0d", k), hist[k][2], 1'b0);
        end

        // Test 2: mid-period interval changes
        bus.run = 1'b0;
        tick();
        chk("t2_idle_led", bus.led, 3'b000);
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (7) tick();
        cfg_write(2'd1, 4'd3, 1'b0);
        repeat (6) tick();
        cfg_write(2'd0, 4'd0, 1'b0);
        repeat (30) tick();
        for (int k = 1; k <= 45; k++) begin
            chk($sformatf("t2_ch1_e%0d", k), hist[k][1],
                (k <= 10) ? periodic(k, 6, 5) : periodic(k, 11, 3));
            chk($sformatf("t2_ch0_e%0d", k), hist[k][0], (k == 11) || (k == 21));
        end
        bus.run = 1'b0;
        cfg_write(2'd0, 4'd10, 1'b0);
        cfg_write(2'd1, 4'd5, 1'b0);

        // Test 3: random intervals on ch2
        cfg_write(2'd2, 4'd1, 1'b1);
        track_gaps = 1'b1;
        bus.run    = 1'b1;
        edge_n     = 0;
        repeat (90) tick();
        track_gaps = 1'b0;
        last   = 1;
        npulse = 0;
        for (int k = 1; k <= 90; k++) begin
            if (hist[k][2] === 1'b1) begin
                npulse++;
                if (gap_q.size() == 0) begin
                    chk("t3_gap_model_empty", 0, 1);
                end else begin
                    g_exp = gap_q.pop_front();
                    chk($sformatf("t3_gap_e%0d", k), k - last, g_exp);
                    chk($sformatf("t3_gap_min_e%0d", k), (k - last) >= 2, 1'b1);
                end
                last = k;
            end
        end
        chk("t3_pulse_count", npulse >= 5, 1'b1);
        gap_q.delete();
        bus.run = 1'b0;
        cfg_write(2'd2, 4'd0, 1'b1);

        // Test 4: run dropped in ARM and in RUN, then restarted
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        chk("t4_arm_drop_running", bus.running, 1'b0);
        chk("t4_arm_drop_led", bus.led, 3'b000);
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (14) tick();
        chk("t4_running_before_drop", bus.running, 1'b1);
        bus.run = 1'b0;
        tick();
        chk("t4_drop_running", bus.running, 1'b0);
        chk("t4_drop_led", bus.led, 3'b000);
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (32) tick();
        for (int k = 1; k <= 32; k++) begin
            chk($sformatf("t4_ch0_e%0d", k), hist[k][0], periodic(k, 11, 10));
            chk($sformatf("t4_ch1_e%0d", k), hist[k][1], periodic(k, 6, 5));
        end

        // Test 5: reset mid-RUN after ch1 was reprogrammed
        cfg_write(2'd1, 4'd7, 1'b0);
        repeat (5) tick();
        rstbtn = 1'b1;
        tick();
        chk("t5_reset_led", bus.led, 3'b000);
        chk("t5_reset_running", bus.running, 1'b0);
        rstbtn = 1'b0;
        edge_n = 0;
        repeat (20) tick();
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("t5_ch1_e%0d", k), hist[k][1], periodic(k, 6, 5));
            chk($sformatf("t5_ch0_e%0d", k), hist[k][0], periodic(k, 11, 10));
        end

        // Test 6a: interval 1 holds led high; write to channel 3 is ignored
        bus.run = 1'b0;
        cfg_write(2'd0, 4'd1, 1'b0);
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (2) tick();
        cfg_write(2'd3, 4'd2, 1'b1);
        repeat (17) tick();
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("t6_ch0_e%0d", k), hist[k][0], k >= 2);
            chk($sformatf("t6_ch1_e%0d", k), hist[k][1], periodic(k, 6, 5));
            chk($sformatf("t6_ch2_e%0d", k), hist[k][2], 1'b0);
        end

        // Test 6b: write on the reload edge uses the old interval once
        bus.run = 1'b0;
        cfg_write(2'd0, 4'd4, 1'b0);
        bus.run = 1'b1;
        edge_n  = 0;
        repeat (8) tick();
        cfg_write(2'd0, 4'd2, 1'b0);
        repeat (11) tick();
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("t6b_ch0_e%0d", k), hist[k][0],
                (k <= 13) ? periodic(k, 5, 4) : periodic(k, 13, 2));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
